// File: rtl/conv_feature_map_streamer_if.sv
// Pixel-stream bus between the feature-map streamer, its plane RAMs and the
// downstream 3-channel conv. The master side is the streamer itself.
interface conv_feature_map_streamer_if #(
   parameter int Datawidth  = 16,
   parameter int Addr_Width = 8
);
   logic                  start;
   logic                  stall;
   logic                  rd_en;
   logic [Addr_Width-1:0] rd_addr;
   logic [Datawidth-1:0]  rd_data_0;
   logic [Datawidth-1:0]  rd_data_1;
   logic [Datawidth-1:0]  rd_data_2;
   logic [Datawidth-1:0]  Out_0;
   logic [Datawidth-1:0]  Out_1;
   logic [Datawidth-1:0]  Out_2;
   logic                  valid_out;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, stall, rd_data_0, rd_data_1, rd_data_2,
      output rd_en, rd_addr, Out_0, Out_1, Out_2, valid_out, busy, done
   );

   modport slave (
      output start, stall, rd_data_0, rd_data_1, rd_data_2,
      input  rd_en, rd_addr, Out_0, Out_1, Out_2, valid_out, busy, done
   );
endinterface

// File: rtl/conv_feature_map_streamer.sv
// Reads a 3-channel feature map from three synchronous plane RAMs and streams
// it in raster order, optionally framed by Pad rows/columns of zeros.
module conv_feature_map_streamer #(
   parameter int IMG_Width  = 7,
   parameter int IMG_Height = 7,
   parameter int Datawidth  = 16,
   parameter int Pad        = 0,
   parameter int Addr_Width = 8
) (
   input logic                         clk,
   input logic                         rst,
   conv_feature_map_streamer_if.master bus
);

   localparam int FRAME_W   = IMG_Width + 2 * Pad;
   localparam int FRAME_H   = IMG_Height + 2 * Pad;
   localparam int FRAME_MAX = (FRAME_W > FRAME_H) ? FRAME_W : FRAME_H;
   // One spare bit of headroom so that (count - Pad) on a leading border
   // wraps to a value that is always larger than the map size.
   localparam int CNT_W     = $clog2(FRAME_MAX + 1) + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      prow, pcol;
   logic [CNT_W-1:0]      row_off, col_off;
   logic                  interior, last_pos, last_col, issue;
   logic [Addr_Width-1:0] addr_q;
   logic                  s1_valid, s1_pad, s1_last;
   logic                  out_last;

   // Offsets into the unpadded map; border positions wrap to large values,
   // so a single unsigned compare per axis classifies the position.
   assign row_off  = prow - CNT_W'(Pad);
   assign col_off  = pcol - CNT_W'(Pad);
   assign interior = (row_off < CNT_W'(IMG_Height)) && (col_off < CNT_W'(IMG_Width));
   assign last_col = (pcol == CNT_W'(FRAME_W - 1));
   assign last_pos = last_col && (prow == CNT_W'(FRAME_H - 1));

   // Next-state logic and the issue strobe for the current position.
   always_comb begin
      // NOTE: every signal written here gets a default first, otherwise paths
      // that skip an assignment would infer a latch.
      state_nx = state;
      issue    = 1'b0;
      case (state)
         IDLE:    if (bus.start) state_nx = STREAM;
         STREAM: begin
            issue = ~bus.stall;
            if (issue && last_pos) state_nx = DRAIN;
         end
         DRAIN:   if (bus.done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // RAM read port: only interior positions read, the address otherwise holds.
   always_comb begin
      bus.rd_en   = issue && interior;
      bus.rd_addr = addr_q;
      if (bus.rd_en)
         bus.rd_addr = Addr_Width'(row_off) * Addr_Width'(IMG_Width) + Addr_Width'(col_off);
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = bus.valid_out && out_last;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Raster position counters over the padded frame, plus the held address.
   always_ff @(posedge clk) begin
      if (rst) begin
         prow   <= '0;
         pcol   <= '0;
         addr_q <= '0;
      end else begin
         if (bus.rd_en) addr_q <= bus.rd_addr;
         if (issue) begin
            if (last_col) begin
               pcol <= '0;
               prow <= last_pos ? '0 : prow + 1'b1;
            end else begin
               pcol <= pcol + 1'b1;
            end
         end
      end
   end

   // Stage 1: tag travelling alongside the RAM read issued last cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_pad   <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= issue;
         s1_pad   <= ~interior;
         s1_last  <= issue && last_pos;
      end
   end

   // Stage 2: capture RAM data (or zero for border) into the output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Out_0     <= '0;
         bus.Out_1     <= '0;
         bus.Out_2     <= '0;
         bus.valid_out <= 1'b0;
         out_last      <= 1'b0;
      end else begin
         bus.valid_out <= s1_valid;
         out_last      <= s1_last;
         if (s1_valid) begin
            bus.Out_0 <= s1_pad ? Datawidth'(0) : bus.rd_data_0;
            bus.Out_1 <= s1_pad ? Datawidth'(0) : bus.rd_data_1;
            bus.Out_2 <= s1_pad ? Datawidth'(0) : bus.rd_data_2;
         end
      end
   end

endmodule
